lmsm_sequencer: RTL and testbench

- Parametrised multi-cycle sequencer for the LM/SM (load/store multiple) instructions, sitting between the decode stage and the register-read stage.
- Replaces the single-cycle priority-encode-and-rewrite-IR approach: a single accepted LM/SM becomes one micro-op per set mask bit, lowest index first.
- Holds fetch/decode while sequencing and supports downstream stall and pipeline flush.

---
 rtl/lmsm_sequencer.sv | 138 +++++++++++++
 tb/tb_lmsm_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands one accepted LM/SM instruction into one micro-op
// per set mask bit, lowest register index first. It sits between decode and
// register-read, holds fetch while it is sequencing, and honours downstream
// stall and pipeline flush.
module lmsm_sequencer #(
    parameter int          NREG   = 8,
    parameter int          AW     = 3,
    parameter logic [3:0]  OPC_LM = 4'b0110,
    parameter logic [3:0]  OPC_SM = 4'b0111
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ir_valid,
    input  logic [15:0]   ir,
    output logic          ir_ready,
    input  logic          stall_in,
    input  logic          flush,
    output logic          hold_fetch,
    output logic          uop_valid,
    output logic          uop_is_sm,
    output logic [AW-1:0] uop_base,
    output logic [AW-1:0] uop_reg,
    output logic [AW-1:0] uop_offset,
    output logic          uop_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    localparam logic [NREG-1:0] MASK_ONE   = NREG'(1);
    localparam logic [AW-1:0]   OFFSET_ONE = AW'(1);

    state_t            state;
    logic [NREG-1:0]   mask_q;
    logic [AW-1:0]     base_q;
    logic [AW-1:0]     offset_q;
    logic              sm_q;

    logic [3:0]        ir_opc;
    logic [NREG-1:0]   ir_mask;
    logic [AW-1:0]     ir_base;
    logic              ir_is_lmsm;
    logic              accept;
    logic              in_seq;
    logic [NREG-1:0]   mask_clr_low;
    logic              mask_single;
    logic              unused_ir_bits;

    // Index of the lowest set bit; scanning downward lets the lowest hit win.
    function automatic logic [AW-1:0] lowest_set(input logic [NREG-1:0] m);
        logic [AW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) r = AW'(i);
        end
        return r;
    endfunction

    // Fit the 3-bit RA field into an AW-wide register address (truncate or
    // zero-extend depending on how many registers this build has).
    function automatic logic [AW-1:0] fit_base(input logic [2:0] ra);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            if (i < 3) r[i] = ra[i];
        end
        return r;
    endfunction

    // Instruction field decode.
    assign ir_opc     = ir[15:12];
    assign ir_mask    = ir[NREG-1:0];
    assign ir_base    = fit_base(ir[11:9]);
    assign ir_is_lmsm = (ir_opc == OPC_LM) || (ir_opc == OPC_SM);

    // Mask bits above NREG-1 are deliberately ignored for narrow builds.
    assign unused_ir_bits = ^ir;

    // Handshake: only flush reaches an output combinationally.
    assign in_seq   = (state == SEQ);
    assign ir_ready = (state == IDLE) && !flush;
    assign accept   = ir_valid && ir_ready && ir_is_lmsm;

    // Mask bookkeeping: drop the bit being consumed; detect the final one.
    assign mask_clr_low = mask_q & (mask_q - MASK_ONE);
    assign mask_single  = (mask_q != '0) && (mask_clr_low == '0);

    // Micro-op outputs are decoded purely from registered state and forced
    // to their inactive values outside SEQ.
    assign hold_fetch = in_seq;
    assign uop_valid  = in_seq;
    assign uop_is_sm  = in_seq && sm_q;
    assign uop_base   = in_seq ? base_q : '0;
    assign uop_reg    = in_seq ? lowest_set(mask_q) : '0;
    assign uop_offset = in_seq ? offset_q : '0;
    assign uop_last   = in_seq && mask_single;

    // Sequencer FSM: flush beats stall, stall beats advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mask_q   <= '0;
            base_q   <= '0;
            offset_q <= '0;
            sm_q     <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            mask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero-mask LM/SM is consumed here with no micro-ops.
                    if (accept && (ir_mask != '0)) begin
                        state    <= SEQ;
                        mask_q   <= ir_mask;
                        base_q   <= ir_base;
                        offset_q <= '0;
                        sm_q     <= (ir_opc == OPC_SM);
                    end
                end
                SEQ: begin
                    if (!stall_in) begin
                        mask_q   <= mask_clr_low;
                        offset_q <= offset_q + OFFSET_ONE;
                        if (mask_single) state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mask_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: an 8-register build carries most of the
// scenarios, a 4-register build checks that high mask bits are ignored.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_valid, stall_in, flush;
    logic [15:0] ir;
    logic        ir_ready, hold_fetch, uop_valid, uop_is_sm, uop_last;
    logic [2:0]  uop_base, uop_reg, uop_offset;

    logic        ir_valid4;
    logic [15:0] ir4;
    logic        ir_ready4, hold_fetch4, uop_valid4, uop_is_sm4, uop_last4;
    logic [1:0]  uop_base4, uop_reg4, uop_offset4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmsm_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir(ir),
        .ir_ready(ir_ready), .stall_in(stall_in), .flush(flush),
        .hold_fetch(hold_fetch), .uop_valid(uop_valid), .uop_is_sm(uop_is_sm),
        .uop_base(uop_base), .uop_reg(uop_reg), .uop_offset(uop_offset),
        .uop_last(uop_last)
    );

    lmsm_sequencer #(.NREG(4), .AW(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid4), .ir(ir4),
        .ir_ready(ir_ready4), .stall_in(1'b0), .flush(1'b0),
        .hold_fetch(hold_fetch4), .uop_valid(uop_valid4), .uop_is_sm(uop_is_sm4),
        .uop_base(uop_base4), .uop_reg(uop_reg4), .uop_offset(uop_offset4),
        .uop_last(uop_last4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Active micro-op on the 8-register instance.
    task automatic exp_uop(input string tag, input logic [15:0] sm, input logic [15:0] base,
                           input logic [15:0] rg, input logic [15:0] off, input logic [15:0] last);
        chk({tag, ".valid"}, 16'(uop_valid), 16'd1);
        chk({tag, ".hold"},  16'(hold_fetch), 16'd1);
        chk({tag, ".ready"}, 16'(ir_ready), 16'd0);
        chk({tag, ".is_sm"}, 16'(uop_is_sm), sm);
        chk({tag, ".base"},  16'(uop_base), base);
        chk({tag, ".reg"},   16'(uop_reg), rg);
        chk({tag, ".off"},   16'(uop_offset), off);
        chk({tag, ".last"},  16'(uop_last), last);
    endtask

    // Inactive outputs on the 8-register instance.
    task automatic exp_idle(input string tag, input logic [15:0] ready);
        chk({tag, ".valid"}, 16'(uop_valid), 16'd0);
        chk({tag, ".hold"},  16'(hold_fetch), 16'd0);
        chk({tag, ".ready"}, 16'(ir_ready), ready);
        chk({tag, ".reg"},   16'(uop_reg), 16'd0);
        chk({tag, ".off"},   16'(uop_offset), 16'd0);
        chk({tag, ".base"},  16'(uop_base), 16'd0);
        chk({tag, ".last"},  16'(uop_last), 16'd0);
        chk({tag, ".is_sm"}, 16'(uop_is_sm), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ir_valid = 1'b0; ir = '0; stall_in = 1'b0; flush = 1'b0;
        ir_valid4 = 1'b0; ir4 = '0;
        #2;
        exp_idle("reset", 16'd1);
        chk("reset4.valid", 16'(uop_valid4), 16'd0);
        chk("reset4.ready", 16'(ir_ready4), 16'd1);
        #10 rst_n = 1'b1;
        tick();

        // LM R2, mask 0xA5 -> regs 0,2,5,7
        ir = 16'h64A5; ir_valid = 1'b1; #1;
        chk("lm.accept_ready", 16'(ir_ready), 16'd1);
        tick(); ir_valid = 1'b0; #1;
        exp_uop("lm.u0", 0, 2, 0, 0, 0);
        tick(); exp_uop("lm.u1", 0, 2, 2, 1, 0);
        tick(); exp_uop("lm.u2", 0, 2, 5, 2, 0);
        tick(); exp_uop("lm.u3", 0, 2, 7, 3, 1);
        tick(); exp_idle("lm.done", 16'd1);

        // SM R5, mask 0x80, stalled three cycles on its only micro-op
        ir = 16'h7A80; ir_valid = 1'b1;
        tick(); ir_valid = 1'b0; stall_in = 1'b1; #1;
        exp_uop("sm.s0", 1, 5, 7, 0, 1);
        tick(); exp_uop("sm.s1", 1, 5, 7, 0, 1);
        tick(); exp_uop("sm.s2", 1, 5, 7, 0, 1);
        tick(); stall_in = 1'b0; #1;
        exp_uop("sm.go", 1, 5, 7, 0, 1);
        tick(); exp_idle("sm.done", 16'd1);

        // LM with empty mask: consumed without micro-ops
        ir = 16'h6400; ir_valid = 1'b1;
        tick(); ir_valid = 1'b0; #1;
        exp_idle("lm0.c1", 16'd1);
        tick(); exp_idle("lm0.c2", 16'd1);

        // SM R1, mask 0xFF, flushed on the third micro-op with an LM waiting
        ir = 16'h72FF; ir_valid = 1'b1;
        tick(); ir_valid = 1'b0; #1;
        exp_uop("flu.u0", 1, 1, 0, 0, 0);
        tick(); exp_uop("flu.u1", 1, 1, 1, 1, 0);
        tick(); flush = 1'b1; ir = 16'h6403; ir_valid = 1'b1; #1;
        exp_uop("flu.u2", 1, 1, 2, 2, 0);
        tick(); flush = 1'b0; #1;
        exp_idle("flu.after", 16'd1);
        tick(); ir_valid = 1'b0; #1;
        exp_uop("flu.lm0", 0, 2, 0, 0, 0);
        tick(); exp_uop("flu.lm1", 0, 2, 1, 1, 1);
        tick(); exp_idle("flu.lmdone", 16'd1);

        // Asynchronous reset during the second micro-op of mask 0x0F
        ir = 16'h640F; ir_valid = 1'b1;
        tick(); ir_valid = 1'b0; #1;
        exp_uop("rst.u0", 0, 2, 0, 0, 0);
        tick(); exp_uop("rst.u1", 0, 2, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 exp_idle("rst.async", 16'd1);
        #2 rst_n = 1'b1;
        tick(); exp_idle("rst.post1", 16'd1);
        tick(); exp_idle("rst.post2", 16'd1);

        // ADD is ignored
        ir = 16'h0AFF; ir_valid = 1'b1; #1;
        chk("add.ready", 16'(ir_ready), 16'd1);
        tick(); exp_idle("add.c1", 16'd1);
        tick(); exp_idle("add.c2", 16'd1);
        ir_valid = 1'b0;

        // 4-register build: IR[3:0]=1001, IR[7:4]=1111 -> regs 0 and 3 only
        ir4 = 16'h66F9; ir_valid4 = 1'b1; #1;
        chk("n4.ready", 16'(ir_ready4), 16'd1);
        tick(); ir_valid4 = 1'b0; #1;
        chk("n4.u0.valid", 16'(uop_valid4), 16'd1);
        chk("n4.u0.base",  16'(uop_base4), 16'd3);
        chk("n4.u0.reg",   16'(uop_reg4), 16'd0);
        chk("n4.u0.off",   16'(uop_offset4), 16'd0);
        chk("n4.u0.last",  16'(uop_last4), 16'd0);
        chk("n4.u0.hold",  16'(hold_fetch4), 16'd1);
        tick();
        chk("n4.u1.valid", 16'(uop_valid4), 16'd1);
        chk("n4.u1.reg",   16'(uop_reg4), 16'd3);
        chk("n4.u1.off",   16'(uop_offset4), 16'd1);
        chk("n4.u1.last",  16'(uop_last4), 16'd1);
        chk("n4.u1.is_sm", 16'(uop_is_sm4), 16'd0);
        tick();
        chk("n4.done.valid", 16'(uop_valid4), 16'd0);
        chk("n4.done.ready", 16'(ir_ready4), 16'd1);
        chk("n4.done.hold",  16'(hold_fetch4), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
